// File: rtl/mips_pipe_pkg.sv
// Shared bit-index constants and state type for the MIPS pipeline stages.
package mips_pipe_pkg;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   localparam int MEM_BRANCH  = 2;
   localparam int MEM_READ    = 1;
   localparam int MEM_WRITE   = 0;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with a bubble input that squashes the whole entry.
// Latency one cycle; readDataOut only reloads when the stage completes a memory access.
module mem_wb_reg (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        bubble,
   input  logic        load_rd,
   input  logic [31:0] rd_in,
   input  logic [31:0] alu_in,
   input  logic [4:0]  dst_in,
   input  logic [1:0]  wb_in,
   output logic [31:0] rd_out,
   output logic [31:0] alu_out,
   output logic [4:0]  dst_out,
   output logic [1:0]  wb_out
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_out  <= '0;
         alu_out <= '0;
         dst_out <= '0;
         wb_out  <= '0;
      end else if (bubble) begin
         rd_out  <= '0;
         alu_out <= '0;
         dst_out <= '0;
         wb_out  <= '0;
      end else begin
         // Non-memory ops keep the last loaded word visible to write-back.
         if (load_rd) begin
            rd_out <= rd_in;
         end
         alu_out <= alu_in;
         dst_out <= dst_in;
         wb_out  <= wb_in;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: branch resolve, req/ack data bus with watchdog, MEM/WB register.
// Optional alignment check guarded by MEM_ALIGN_CHECK_EN (adds the misaligned pulse output).
module mem_stage
   import mips_pipe_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [31:0]       addPc,
   input  logic [31:0]       aluResult,
   input  logic              zero,
   input  logic [31:0]       readData2,
   input  logic [4:0]        muxInst,
   input  logic [1:0]        WB,
   input  logic [2:0]        MEM,
   output logic              pcSrc,
   output logic [31:0]       branchTarget,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              bus_err,
   output logic [31:0]       readDataOut,
   output logic [31:0]       aluResultOut,
   output logic [4:0]        muxInstOut,
   output logic [1:0]        WBOut
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic              misaligned
`endif
);

   localparam int CW = $clog2(TIMEOUT + 1);

   mem_state_t    state;
   logic [CW-1:0] count;

   logic access;
   logic is_write;
   logic misalign;
   logic eff_access;
   logic abort;
   logic complete;
   logic bubble;
   logic [31:0] rd_next;

   assign access   = MEM[MEM_READ] | MEM[MEM_WRITE];
   assign is_write = MEM[MEM_WRITE];

`ifdef MEM_ALIGN_CHECK_EN
   // Only checked on entry; the address is held stable while waiting.
   assign misalign = reset_n & (state == IDLE) & access & (aluResult[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign eff_access = access & ~misalign;
   assign abort      = reset_n & (state == WAIT) & ~mem_ack & (count == CW'(TIMEOUT));

   assign pcSrc        = MEM[MEM_BRANCH] & zero;
   assign branchTarget = addPc;
   assign mem_we       = is_write;
   assign mem_addr     = ADDR_W'(aluResult);
   assign mem_wdata    = readData2;

   always_comb begin
      mem_req = 1'b0;
      stall   = 1'b0;
      if (reset_n) begin
         if (state == WAIT) begin
            mem_req = ~abort;
            stall   = ~mem_ack & ~abort;
         end else begin
            mem_req = eff_access;
            stall   = eff_access & ~mem_ack;
         end
      end
   end

   assign complete = mem_req & mem_ack;
   assign bubble   = stall | abort | misalign;
   // A write (including read+write) leaves nothing to load back.
   assign rd_next  = is_write ? 32'h0 : mem_rdata;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         count   <= '0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= abort | misalign;
         case (state)
            IDLE: begin
               if (eff_access & ~mem_ack) begin
                  state <= WAIT;
                  count <= CW'(1);
               end
            end
            WAIT: begin
               if (mem_ack | abort) begin
                  state <= IDLE;
                  count <= '0;
               end else begin
                  count <= count + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
            end
         endcase
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         misaligned <= 1'b0;
      end else begin
         misaligned <= misalign;
      end
   end
`endif

   mem_wb_reg u_mem_wb (
      .clock   (clock),
      .reset_n (reset_n),
      .bubble  (bubble),
      .load_rd (complete),
      .rd_in   (rd_next),
      .alu_in  (aluResult),
      .dst_in  (muxInst),
      .wb_in   (WB),
      .rd_out  (readDataOut),
      .alu_out (aluResultOut),
      .dst_out (muxInstOut),
      .wb_out  (WBOut)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset-in-WAIT sequence, then random
// transactions checked against a transaction-level model of the stage.
module tb_mem_stage;

   localparam int TO = 4;

   logic        clock;
   logic        reset_n;
   logic [31:0] addPc;
   logic [31:0] aluResult;
   logic        zero;
   logic [31:0] readData2;
   logic [4:0]  muxInst;
   logic [1:0]  WB;
   logic [2:0]  MEM;
   logic        pcSrc;
   logic [31:0] branchTarget;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        bus_err;
   logic [31:0] readDataOut;
   logic [31:0] aluResultOut;
   logic [4:0]  muxInstOut;
   logic [1:0]  WBOut;

   mem_stage #(.TIMEOUT(TO), .ADDR_W(32)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .addPc        (addPc),
      .aluResult    (aluResult),
      .zero         (zero),
      .readData2    (readData2),
      .muxInst      (muxInst),
      .WB           (WB),
      .MEM          (MEM),
      .pcSrc        (pcSrc),
      .branchTarget (branchTarget),
      .stall        (stall),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack),
      .bus_err      (bus_err),
      .readDataOut  (readDataOut),
      .aluResultOut (aluResultOut),
      .muxInstOut   (muxInstOut),
      .WBOut        (WBOut)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  wb;
      logic [2:0]  mem;
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [4:0]  mux;
      logic        zero;
      logic [31:0] addpc;
      int          waits;   // cycle index of the ack; beyond TO means never
      logic [31:0] rdata;
   } txn_t;

   typedef struct {
      int          stall_cyc;
      logic        err;
      logic [1:0]  wbo;
      logic [31:0] rdo;
      logic [31:0] alo;
      logic [4:0]  muxo;
      logic        pcsrc;
   } exp_t;

   typedef struct {
      txn_t t;
      exp_t e;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] last_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic txn_t mk_txn(input logic [1:0] wb, input logic [2:0] mem,
                                   input logic [31:0] alu, input logic [31:0] wdata,
                                   input logic [4:0] mux, input logic zr,
                                   input logic [31:0] addpc, input int waits,
                                   input logic [31:0] rdata);
      txn_t t;
      t.wb = wb; t.mem = mem; t.alu = alu; t.wdata = wdata; t.mux = mux;
      t.zero = zr; t.addpc = addpc; t.waits = waits; t.rdata = rdata;
      return t;
   endfunction

   function automatic exp_t mk_exp(input int sc, input logic err, input logic [1:0] wbo,
                                   input logic [31:0] rdo, input logic [31:0] alo,
                                   input logic [4:0] muxo, input logic pcsrc);
      exp_t e;
      e.stall_cyc = sc; e.err = err; e.wbo = wbo; e.rdo = rdo;
      e.alo = alo; e.muxo = muxo; e.pcsrc = pcsrc;
      return e;
   endfunction

   // Transaction-level view: an access stalls for min(waits, TO) cycles and
   // either completes or, if the ack never comes in time, is aborted.
   function automatic exp_t model(input txn_t t, input logic [31:0] prev_rd);
      exp_t e;
      bit acc;
      acc = (t.mem[1] | t.mem[0]);
      e.pcsrc = t.mem[2] & t.zero;
      e.stall_cyc = !acc ? 0 : (t.waits < TO ? t.waits : TO);
      e.err = acc && (t.waits > TO);
      if (e.err) begin
         e.wbo = 2'b00; e.rdo = 32'h0; e.alo = 32'h0; e.muxo = 5'd0;
      end else begin
         e.wbo = t.wb; e.alo = t.alu; e.muxo = t.mux;
         if (!acc)          e.rdo = prev_rd;
         else if (t.mem[0]) e.rdo = 32'h0;
         else               e.rdo = t.rdata;
      end
      return e;
   endfunction

   task automatic drive(input txn_t t);
      WB = t.wb; MEM = t.mem; aluResult = t.alu; readData2 = t.wdata;
      muxInst = t.mux; zero = t.zero; addPc = t.addpc;
   endtask

   task automatic drive_nop();
      WB = 2'b00; MEM = 3'b000; aluResult = 32'h0; readData2 = 32'h0;
      muxInst = 5'd0; zero = 1'b0; addPc = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
   endtask

   // Entered and left just after a rising edge.
   task automatic run_txn(input txn_t t, input exp_t e);
      bit acc;
      bit exp_req;
      acc = (t.mem[1] | t.mem[0]);
      drive(t);
      for (int k = 0; k <= e.stall_cyc; k++) begin
         mem_ack   = (t.waits == k);
         mem_rdata = (t.waits == k) ? t.rdata : $urandom;
         @(negedge clock);
         exp_req = acc && !(e.err && k == e.stall_cyc);
         chk("pcSrc", pcSrc, e.pcsrc);
         chk("branchTarget", branchTarget, t.addpc);
         chk("stall", stall, (k < e.stall_cyc));
         chk("mem_req", mem_req, exp_req);
         if (exp_req) begin
            chk("mem_addr", mem_addr, t.alu);
            chk("mem_we", mem_we, t.mem[0]);
            if (t.mem[0]) chk("mem_wdata", mem_wdata, t.wdata);
         end
         @(posedge clock);
         #1;
         if (k < e.stall_cyc) begin
            chk("WBOut_bubble", WBOut, 2'b00);
            chk("bus_err_wait", bus_err, 1'b0);
         end else begin
            chk("WBOut", WBOut, e.wbo);
            chk("aluResultOut", aluResultOut, e.alo);
            chk("muxInstOut", muxInstOut, e.muxo);
            chk("readDataOut", readDataOut, e.rdo);
            chk("bus_err", bus_err, e.err);
         end
      end
      mem_ack = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "time limit");
   end

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{t: mk_txn(2'b10, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b0, 32'h0, 1, 32'h5555),
                  e: mk_exp(0, 1'b0, 2'b10, 32'h0, 32'h1234, 5'd5, 1'b0)};
      tbl[1]  = '{t: mk_txn(2'b11, 3'b010, 32'h40, 32'h0, 5'd8, 1'b0, 32'h0, 3, 32'hDEADBEEF),
                  e: mk_exp(3, 1'b0, 2'b11, 32'hDEADBEEF, 32'h40, 5'd8, 1'b0)};
      tbl[2]  = '{t: mk_txn(2'b10, 3'b000, 32'h77, 32'h0, 5'd3, 1'b0, 32'h0, 0, 32'h1111),
                  e: mk_exp(0, 1'b0, 2'b10, 32'hDEADBEEF, 32'h77, 5'd3, 1'b0)};
      tbl[3]  = '{t: mk_txn(2'b00, 3'b001, 32'h80, 32'hCAFEF00D, 5'd0, 1'b0, 32'h0, 0, 32'h9999),
                  e: mk_exp(0, 1'b0, 2'b00, 32'h0, 32'h80, 5'd0, 1'b0)};
      tbl[4]  = '{t: mk_txn(2'b00, 3'b100, 32'h0, 32'h0, 5'd0, 1'b1, 32'h100, 5, 32'h0),
                  e: mk_exp(0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1)};
      tbl[5]  = '{t: mk_txn(2'b00, 3'b100, 32'h0, 32'h0, 5'd0, 1'b0, 32'h100, 5, 32'h0),
                  e: mk_exp(0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0)};
      tbl[6]  = '{t: mk_txn(2'b11, 3'b010, 32'h44, 32'h0, 5'd9, 1'b0, 32'h0, 99, 32'h0),
                  e: mk_exp(TO, 1'b1, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0)};
      tbl[7]  = '{t: mk_txn(2'b11, 3'b010, 32'h48, 32'h0, 5'd10, 1'b0, 32'h0, TO, 32'h0BADF00D),
                  e: mk_exp(TO, 1'b0, 2'b11, 32'h0BADF00D, 32'h48, 5'd10, 1'b0)};
      tbl[8]  = '{t: mk_txn(2'b10, 3'b011, 32'h4C, 32'h12345678, 5'd11, 1'b0, 32'h0, 1, 32'hFFFFFFFF),
                  e: mk_exp(1, 1'b0, 2'b10, 32'h0, 32'h4C, 5'd11, 1'b0)};
      tbl[9]  = '{t: mk_txn(2'b11, 3'b010, 32'h50, 32'h0, 5'd12, 1'b0, 32'h0, 0, 32'h11223344),
                  e: mk_exp(0, 1'b0, 2'b11, 32'h11223344, 32'h50, 5'd12, 1'b0)};
      tbl[10] = '{t: mk_txn(2'b11, 3'b110, 32'h54, 32'h0, 5'd13, 1'b1, 32'h200, 2, 32'hA5A5A5A5),
                  e: mk_exp(2, 1'b0, 2'b11, 32'hA5A5A5A5, 32'h54, 5'd13, 1'b1)};

      // Reset with a load presented and ack high: bus stays quiet.
      reset_n = 1'b0;
      drive(tbl[1].t);
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      #3;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_WBOut", WBOut, 2'b00);
      chk("rst_readDataOut", readDataOut, 32'h0);
      chk("rst_aluResultOut", aluResultOut, 32'h0);
      chk("rst_muxInstOut", muxInstOut, 5'd0);
      chk("rst_bus_err", bus_err, 1'b0);
      @(posedge clock); #1;
      chk("rst_hold_WBOut", WBOut, 2'b00);
      drive_nop();
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;

      for (int i = 0; i < 11; i++) begin
         run_txn(tbl[i].t, tbl[i].e);
      end

      // Reset asserted while waiting on the bus.
      drive(tbl[6].t);
      mem_ack = 1'b0;
      @(negedge clock);
      chk("mw_stall0", stall, 1'b1);
      @(posedge clock); #1;
      @(negedge clock);
      chk("mw_stall1", stall, 1'b1);
      chk("mw_req1", mem_req, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      chk("mw_req_drop", mem_req, 1'b0);
      chk("mw_stall_drop", stall, 1'b0);
      chk("mw_WBOut", WBOut, 2'b00);
      chk("mw_readDataOut", readDataOut, 32'h0);
      chk("mw_aluResultOut", aluResultOut, 32'h0);
      chk("mw_bus_err", bus_err, 1'b0);
      @(posedge clock); #1;
      drive_nop();
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < TO + 2; c++) begin
         @(posedge clock); #1;
         chk("mw_no_bus_err", bus_err, 1'b0);
      end
      last_rd = 32'h0;
      run_txn(tbl[0].t, model(tbl[0].t, last_rd));

      for (int n = 0; n < 300; n++) begin
         txn_t t;
         exp_t e;
         int kind;
         kind = $urandom_range(0, 4);
         t.wb    = 2'($urandom);
         t.alu   = $urandom & 32'hFFFF_FFFC;
         t.wdata = $urandom;
         t.mux   = 5'($urandom);
         t.zero  = 1'($urandom);
         t.addpc = $urandom;
         t.rdata = $urandom;
         case (kind)
            0:       t.mem = {1'($urandom), 2'b00};
            1, 2:    t.mem = {1'($urandom), 2'b10};
            3:       t.mem = {1'($urandom), 2'b01};
            default: t.mem = {1'($urandom), 2'b11};
         endcase
         if (kind == 0)               t.waits = $urandom_range(0, 1);
         else if ($urandom_range(0, 3) == 0) t.waits = 0;
         else                         t.waits = $urandom_range(0, TO + 2);
         e = model(t, last_rd);
         run_txn(t, e);
         last_rd = e.rdo;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
